// File: rtl/instr_fetch_if.sv
// Fetch-stage signal bundle between the PC/IF-ID logic and the rest of the pipeline.
// With PC_ALIGN_CHECK_EN defined the bundle also carries the sticky misalign flag.
interface instr_fetch_if;
    logic        stall_i;
    logic        flush_i;
    logic        branch_i;
    logic [31:0] branch_target_i;
    logic        jump_i;
    logic [31:0] jump_target_i;
    logic [31:0] pc_addr_o;
    logic [31:0] instr_i;
    logic [31:0] ifid_instr_o;
    logic [31:0] ifid_pc4_o;
    logic        ifid_valid_o;
    logic        oob_o;
`ifdef PC_ALIGN_CHECK_EN
    logic        misalign_o;

    modport master (
        input  stall_i, flush_i, branch_i, branch_target_i,
        input  jump_i, jump_target_i, instr_i,
        output pc_addr_o, ifid_instr_o, ifid_pc4_o, ifid_valid_o, oob_o,
        output misalign_o
    );

    modport slave (
        output stall_i, flush_i, branch_i, branch_target_i,
        output jump_i, jump_target_i, instr_i,
        input  pc_addr_o, ifid_instr_o, ifid_pc4_o, ifid_valid_o, oob_o,
        input  misalign_o
    );
`else
    modport master (
        input  stall_i, flush_i, branch_i, branch_target_i,
        input  jump_i, jump_target_i, instr_i,
        output pc_addr_o, ifid_instr_o, ifid_pc4_o, ifid_valid_o, oob_o
    );

    modport slave (
        output stall_i, flush_i, branch_i, branch_target_i,
        output jump_i, jump_target_i, instr_i,
        input  pc_addr_o, ifid_instr_o, ifid_pc4_o, ifid_valid_o, oob_o
    );
`endif
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// Optional macro PC_ALIGN_CHECK_EN forces redirect targets word-aligned and raises a sticky misalign_o.
module instr_fetch #(
    parameter logic [31:0] PC_RESET   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 32
) (
    input logic           clk_i,
    input logic           rst_i,
    instr_fetch_if.master bus
);

    localparam logic [32:0] OOB_LIMIT = 33'(4 * IMEM_WORDS);

    logic [31:0] pc_q;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        oob;

    logic [31:0] ifid_instr_q;
    logic [31:0] ifid_pc4_q;
    logic        ifid_valid_q;

`ifdef PC_ALIGN_CHECK_EN
    logic        misalign_q;
    logic        target_misaligned;
`endif

    assign pc_plus4 = pc_q + 32'd4;
    assign oob      = ({1'b0, pc_q} >= OOB_LIMIT);

    // Redirects outrank stall so a resolved branch/jump is never lost behind a hazard.
    always_comb begin
        redirect        = bus.jump_i | bus.branch_i;
        redirect_target = bus.jump_i ? bus.jump_target_i : bus.branch_target_i;
`ifdef PC_ALIGN_CHECK_EN
        target_misaligned = redirect && (redirect_target[1:0] != 2'b00);
        redirect_target   = {redirect_target[31:2], 2'b00};
`endif
        if (redirect) begin
            pc_next = redirect_target;
        end else if (bus.stall_i) begin
            pc_next = pc_q;
        end else begin
            pc_next = pc_plus4;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_next;
        end
    end

    // Flush beats stall in IF/ID even though the PC may still be held by the stall.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ifid_instr_q <= 32'd0;
            ifid_pc4_q   <= 32'd0;
            ifid_valid_q <= 1'b0;
        end else if (bus.flush_i) begin
            ifid_instr_q <= 32'd0;
            ifid_pc4_q   <= 32'd0;
            ifid_valid_q <= 1'b0;
        end else if (bus.stall_i) begin
            ifid_instr_q <= ifid_instr_q;
            ifid_pc4_q   <= ifid_pc4_q;
            ifid_valid_q <= ifid_valid_q;
        end else if (oob) begin
            ifid_instr_q <= 32'd0;
            ifid_pc4_q   <= pc_plus4;
            ifid_valid_q <= 1'b0;
        end else begin
            ifid_instr_q <= bus.instr_i;
            ifid_pc4_q   <= pc_plus4;
            ifid_valid_q <= 1'b1;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            misalign_q <= 1'b0;
        end else if (target_misaligned) begin
            misalign_q <= 1'b1;
        end
    end

    assign bus.misalign_o = misalign_q;
`endif

    assign bus.pc_addr_o    = pc_q;
    assign bus.oob_o        = oob;
    assign bus.ifid_instr_o = ifid_instr_q;
    assign bus.ifid_pc4_o   = ifid_pc4_q;
    assign bus.ifid_valid_o = ifid_valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: vector table through a scoreboard queue, plus reset and alignment sequences.
// Build with PC_ALIGN_CHECK_EN defined to exercise the alignment option.
module tb_instr_fetch;

    logic clk_i;
    logic rst_i;

    instr_fetch_if bus ();

    instr_fetch #(
        .PC_RESET   (32'h0000_0000),
        .IMEM_WORDS (32)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    typedef struct {
        logic        stall;
        logic        flush;
        logic        branch;
        logic [31:0] btgt;
        logic        jump;
        logic [31:0] jtgt;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
        logic        e_oob;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        oob;
    } exp_t;

    vec_t vectors[$];
    exp_t sb[$];
    int   checks;
    int   errors;

    // Memory model: every address returns a distinct non-zero word.
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    assign bus.instr_i = imem_word(bus.pc_addr_o);

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "[TB] timeout");
    end

    function automatic vec_t mk(input logic stall, input logic flush,
                                input logic branch, input logic [31:0] btgt,
                                input logic jump, input logic [31:0] jtgt,
                                input logic [31:0] e_pc, input logic [31:0] e_instr,
                                input logic [31:0] e_pc4, input logic e_valid,
                                input logic e_oob);
        vec_t v;
        v.stall = stall;  v.flush = flush;
        v.branch = branch; v.btgt = btgt;
        v.jump = jump;    v.jtgt = jtgt;
        v.e_pc = e_pc;    v.e_instr = e_instr;
        v.e_pc4 = e_pc4;  v.e_valid = e_valid;
        v.e_oob = e_oob;
        return v;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic driveInputs(input logic stall, input logic flush,
                               input logic branch, input logic [31:0] btgt,
                               input logic jump, input logic [31:0] jtgt);
        bus.stall_i         = stall;
        bus.flush_i         = flush;
        bus.branch_i        = branch;
        bus.branch_target_i = btgt;
        bus.jump_i          = jump;
        bus.jump_target_i   = jtgt;
    endtask

    task automatic pushExpect(input logic [31:0] pc, input logic [31:0] instr,
                              input logic [31:0] pc4, input logic valid, input logic oob);
        exp_t e;
        e.pc = pc; e.instr = instr; e.pc4 = pc4; e.valid = valid; e.oob = oob;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input vec_t v);
        driveInputs(v.stall, v.flush, v.branch, v.btgt, v.jump, v.jtgt);
        pushExpect(v.e_pc, v.e_instr, v.e_pc4, v.e_valid, v.e_oob);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s scoreboard: got empty queue required an entry", tag);
        end else begin
            e = sb.pop_front();
            checkValue({tag, " pc"},    bus.pc_addr_o,             e.pc);
            checkValue({tag, " instr"}, bus.ifid_instr_o,          e.instr);
            checkValue({tag, " pc4"},   bus.ifid_pc4_o,            e.pc4);
            checkValue({tag, " valid"}, {31'd0, bus.ifid_valid_o}, {31'd0, e.valid});
            checkValue({tag, " oob"},   {31'd0, bus.oob_o},        {31'd0, e.oob});
        end
    endtask

    task automatic stepAndCheck(input string tag);
        @(posedge clk_i);
        #1;
        checkOutput(tag);
        @(negedge clk_i);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_i  = 1'b0;
        driveInputs(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);

        //          stall flush br  btgt          jmp jtgt          pc            instr                pc4           v     oob
        vectors.push_back(mk(0, 0, 0, 32'h0,       0, 32'h0,         32'h04,       imem_word(32'h00),   32'h04,       1'b1, 1'b0));
        vectors.push_back(mk(0, 0, 0, 32'h0,       0, 32'h0,         32'h08,       imem_word(32'h04),   32'h08,       1'b1, 1'b0));
        vectors.push_back(mk(1, 0, 0, 32'h0,       0, 32'h0,         32'h08,       imem_word(32'h04),   32'h08,       1'b1, 1'b0));
        vectors.push_back(mk(1, 0, 0, 32'h0,       0, 32'h0,         32'h08,       imem_word(32'h04),   32'h08,       1'b1, 1'b0));
        vectors.push_back(mk(0, 0, 0, 32'h0,       0, 32'h0,         32'h0C,       imem_word(32'h08),   32'h0C,       1'b1, 1'b0));
        vectors.push_back(mk(0, 0, 0, 32'h0,       0, 32'h0,         32'h10,       imem_word(32'h0C),   32'h10,       1'b1, 1'b0));
        vectors.push_back(mk(1, 1, 0, 32'h0,       0, 32'h0,         32'h10,       32'h0,               32'h0,        1'b0, 1'b0));
        vectors.push_back(mk(0, 0, 0, 32'h0,       0, 32'h0,         32'h14,       imem_word(32'h10),   32'h14,       1'b1, 1'b0));
        vectors.push_back(mk(1, 0, 1, 32'h40,      1, 32'h20,        32'h20,       imem_word(32'h10),   32'h14,       1'b1, 1'b0));
        vectors.push_back(mk(0, 0, 1, 32'h7C,      0, 32'h0,         32'h7C,       imem_word(32'h20),   32'h24,       1'b1, 1'b0));
        vectors.push_back(mk(0, 0, 0, 32'h0,       0, 32'h0,         32'h80,       imem_word(32'h7C),   32'h80,       1'b1, 1'b1));
        vectors.push_back(mk(0, 0, 0, 32'h0,       0, 32'h0,         32'h84,       32'h0,               32'h84,       1'b0, 1'b1));
        vectors.push_back(mk(0, 0, 0, 32'h0,       1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,              32'h88,       1'b0, 1'b1));
        vectors.push_back(mk(0, 0, 0, 32'h0,       0, 32'h0,         32'h00,       32'h0,               32'h00,       1'b0, 1'b0));
        vectors.push_back(mk(0, 0, 0, 32'h0,       0, 32'h0,         32'h04,       imem_word(32'h00),   32'h04,       1'b1, 1'b0));
        vectors.push_back(mk(0, 1, 1, 32'h30,      0, 32'h0,         32'h30,       32'h0,               32'h0,        1'b0, 1'b0));
        vectors.push_back(mk(0, 0, 0, 32'h0,       0, 32'h0,         32'h34,       imem_word(32'h30),   32'h34,       1'b1, 1'b0));
        vectors.push_back(mk(1, 0, 1, 32'h50,      0, 32'h0,         32'h50,       imem_word(32'h30),   32'h34,       1'b1, 1'b0));

        #2;
        checkValue("reset pc",    bus.pc_addr_o,             32'h0);
        checkValue("reset instr", bus.ifid_instr_o,          32'h0);
        checkValue("reset pc4",   bus.ifid_pc4_o,            32'h0);
        checkValue("reset valid", {31'd0, bus.ifid_valid_o}, 32'd0);
`ifdef PC_ALIGN_CHECK_EN
        checkValue("reset misalign", {31'd0, bus.misalign_o}, 32'd0);
`endif

        @(negedge clk_i);
        rst_i = 1'b1;
        for (int i = 0; i < vectors.size(); i++) begin
            applyStimulus(vectors[i]);
            stepAndCheck($sformatf("vec%0d", i));
        end

        // Reset asserted between edges while a stalled jump is pending.
        $display("[TB] async reset during stalled redirect");
        driveInputs(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h60);
        #2;
        rst_i = 1'b0;
        #1;
        checkValue("async rst pc",    bus.pc_addr_o,             32'h0);
        checkValue("async rst instr", bus.ifid_instr_o,          32'h0);
        checkValue("async rst pc4",   bus.ifid_pc4_o,            32'h0);
        checkValue("async rst valid", {31'd0, bus.ifid_valid_o}, 32'd0);
        @(posedge clk_i);
        #1;
        checkValue("held rst pc", bus.pc_addr_o, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;
        driveInputs(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        pushExpect(32'h04, imem_word(32'h00), 32'h04, 1'b1, 1'b0);
        stepAndCheck("post rst");

        $display("[TB] misaligned jump target");
        driveInputs(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h22);
`ifdef PC_ALIGN_CHECK_EN
        pushExpect(32'h20, imem_word(32'h04), 32'h08, 1'b1, 1'b0);
        stepAndCheck("align jump");
        checkValue("misalign set", {31'd0, bus.misalign_o}, 32'd1);
        driveInputs(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        pushExpect(32'h24, imem_word(32'h20), 32'h24, 1'b1, 1'b0);
        stepAndCheck("align next");
        checkValue("misalign sticky", {31'd0, bus.misalign_o}, 32'd1);
        rst_i = 1'b0;
        #1;
        checkValue("misalign cleared", {31'd0, bus.misalign_o}, 32'd0);
        rst_i = 1'b1;
`else
        pushExpect(32'h22, imem_word(32'h04), 32'h08, 1'b1, 1'b0);
        stepAndCheck("raw jump");
        driveInputs(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        pushExpect(32'h26, imem_word(32'h22), 32'h26, 1'b1, 1'b0);
        stepAndCheck("raw next");
`endif

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard drain: got %0d entries required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
